// File: rtl/serial_magnitude_comparator_pkg.sv
// rtl/serial_magnitude_comparator_pkg.sv - shared state/verdict encodings for the serial comparator
package serial_magnitude_comparator_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      V_EQ = 2'd0,
      V_GT = 2'd1,
      V_LT = 2'd2
   } verdict_t;

   function automatic verdict_t bit_verdict(input logic bit_gt, input logic bit_lt);
      if (bit_gt)
         return V_GT;
      else if (bit_lt)
         return V_LT;
      else
         return V_EQ;
   endfunction

endpackage

// File: rtl/serial_magnitude_comparator_bit_compare_cell.sv
// rtl/serial_magnitude_comparator_bit_compare_cell.sv - combinational one-bit magnitude compare cell
module bit_compare_cell (
   input  logic a_bit_i,
   input  logic b_bit_i,
   output logic bit_gt_o,
   output logic bit_lt_o,
   output logic bit_eq_o
);

   assign bit_gt_o = a_bit_i & ~b_bit_i;
   assign bit_lt_o = ~a_bit_i & b_bit_i;
   assign bit_eq_o = ~(a_bit_i ^ b_bit_i);

endmodule

// File: rtl/serial_magnitude_comparator.sv
// rtl/serial_magnitude_comparator.sv - MSB-first bit-serial unsigned comparator with registered verdict
module serial_magnitude_comparator
   import serial_magnitude_comparator_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic in_valid,
   input  logic a_bit,
   input  logic b_bit,
   output logic busy,
   output logic done,
   output logic gt,
   output logic lt,
   output logic eq
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic          decided_q, decided_d;
   verdict_t      verdict_q, verdict_d;
   logic          busy_q, done_q, gt_q, lt_q, eq_q;

   logic          bit_gt, bit_lt, bit_eq;

   bit_compare_cell u_cell (
      .a_bit_i  (a_bit),
      .b_bit_i  (b_bit),
      .bit_gt_o (bit_gt),
      .bit_lt_o (bit_lt),
      .bit_eq_o (bit_eq)
   );

   // First differing pair from the MSB latches the verdict; later pairs are ignored.
   always_comb begin
      decided_d = decided_q;
      verdict_d = verdict_q;
      if (!decided_q && !bit_eq) begin
         decided_d = 1'b1;
         verdict_d = bit_verdict(bit_gt, bit_lt);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         decided_q <= 1'b0;
         verdict_q <= V_EQ;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         gt_q      <= 1'b0;
         lt_q      <= 1'b0;
         eq_q      <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  state_q   <= ST_SHIFT;
                  busy_q    <= 1'b1;
                  cnt_q     <= '0;
                  decided_q <= 1'b0;
                  verdict_q <= V_EQ;
                  gt_q      <= 1'b0;
                  lt_q      <= 1'b0;
                  eq_q      <= 1'b0;
               end
            end
            ST_SHIFT: begin
               if (in_valid) begin
                  decided_q <= decided_d;
                  verdict_q <= verdict_d;
                  if (cnt_q == CNT_LAST) begin
                     state_q <= ST_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     gt_q    <= (verdict_d == V_GT);
                     lt_q    <= (verdict_d == V_LT);
                     eq_q    <= ~decided_d;
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                  end
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign gt   = gt_q;
   assign lt   = lt_q;
   assign eq   = eq_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// tb/tb_serial_magnitude_comparator.sv - randomized self-checking bench for serial_magnitude_comparator
module tb_serial_magnitude_comparator;

   localparam int W = 4;

   logic clk = 1'b0;
   logic rst, start, in_valid, a_bit, b_bit;
   logic busy, done, gt, lt, eq;

   int   vectors = 0;
   int   miscompares = 0;
   int   cycle = 0;

   logic       chk_en = 1'b0;
   logic [4:0] exp_vec = '0;   // {busy, done, gt, lt, eq}

   serial_magnitude_comparator #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .in_valid (in_valid),
      .a_bit    (a_bit),
      .b_bit    (b_bit),
      .busy     (busy),
      .done     (done),
      .gt       (gt),
      .lt       (lt),
      .eq       (eq)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   always @(negedge clk) begin
      if (chk_en) begin
         vectors = vectors + 1;
         if ({busy, done, gt, lt, eq} !== exp_vec) begin
            miscompares = miscompares + 1;
            $display("FAIL outputs cycle=%0d {busy,done,gt,lt,eq} got=%b want=%b",
                     cycle, {busy, done, gt, lt, eq}, exp_vec);
         end
      end
   end

   task automatic chk(input string name, input int act, input int want);
      vectors = vectors + 1;
      if (act != want) begin
         miscompares = miscompares + 1;
         $display("FAIL %s got=%0d want=%0d", name, act, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [4:0] result_vec(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic is_done);
      return {1'b0, is_done, a > b, a < b, a == b};
   endfunction

   // Runs one comparison; stalls come from stall_pct (random) plus an optional
   // burst of stall_len idle cycles once stall_after pairs have been consumed.
   task automatic run_cmp(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int stall_pct, input int stall_after, input int stall_len,
                          input bit noise, output int lat, output int busyc);
      int idx;
      int stalled;
      bit v;
      lat     = 0;
      busyc   = 0;
      stalled = 0;
      start    = 1'b1;
      in_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      a_bit    = 1'($urandom_range(0, 1));
      b_bit    = 1'($urandom_range(0, 1));
      tick();
      lat = 1;
      if (busy) busyc++;
      exp_vec = 5'b10000;
      idx = W - 1;
      while (idx >= 0) begin
         if (stall_after == (W - 1 - idx) && stalled < stall_len) begin
            v = 1'b0;
            stalled++;
         end else begin
            v = ($urandom_range(0, 99) >= stall_pct);
         end
         in_valid = v;
         start    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         a_bit    = v ? a[idx] : 1'($urandom_range(0, 1));
         b_bit    = v ? b[idx] : 1'($urandom_range(0, 1));
         tick();
         lat++;
         if (busy) busyc++;
         if (v) begin
            if (idx == 0) exp_vec = result_vec(a, b, 1'b1);
            idx--;
         end
         if (lat > 200) begin
            chk("run_cmp_budget", lat, 200);
            idx = -1;
         end
      end
      chk("done_at_end", int'(done), 1);
      start    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      in_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      exp_vec = result_vec(a, b, 1'b0);
      start    = 1'b0;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n, input logic [W-1:0] a, input logic [W-1:0] b, input bit have_result);
      for (int i = 0; i < n; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         a_bit    = 1'($urandom_range(0, 1));
         b_bit    = 1'($urandom_range(0, 1));
         tick();
         exp_vec = have_result ? result_vec(a, b, 1'b0) : 5'b00000;
      end
      in_valid = 1'b0;
   endtask

   task automatic abort_cmp(input logic [W-1:0] a, input logic [W-1:0] b, input int nbits);
      start = 1'b1;
      in_valid = 1'b0;
      tick();
      start = 1'b0;
      exp_vec = 5'b10000;
      for (int i = 0; i < nbits; i++) begin
         in_valid = 1'b1;
         a_bit = a[W-1-i];
         b_bit = b[W-1-i];
         tick();
      end
      rst   = 1'b1;
      start = 1'b1;
      tick();
      exp_vec = 5'b00000;
      rst   = 1'b0;
      start = 1'b0;
      in_valid = 1'b0;
      tick();
   endtask

   initial begin
      int lat, busyc;
      logic [W-1:0] a, b;
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; a_bit = 1'b0; b_bit = 1'b0;
      tick();
      chk_en = 1'b1;
      exp_vec = 5'b00000;
      tick();
      rst = 1'b0;
      idle(2, '0, '0, 1'b0);

      run_cmp(4'b1010, 4'b1001, 0, -1, 0, 1'b0, lat, busyc);
      chk("lat_1010_1001", lat, 5);
      chk("busy_cycles_1010_1001", busyc, 4);
      chk("gt_1010_1001", int'(gt), 1);

      run_cmp(4'b0110, 4'b0110, 0, -1, 0, 1'b0, lat, busyc);
      chk("eq_0110_0110", int'(eq), 1);
      idle(10, 4'b0110, 4'b0110, 1'b1);
      chk("eq_hold_0110", int'({gt, lt, eq}), 1);

      run_cmp(4'b0111, 4'b1000, 0, -1, 0, 1'b0, lat, busyc);
      chk("lt_0111_1000", int'({gt, lt, eq}), 2);

      run_cmp(4'b1100, 4'b1011, 0, 2, 2, 1'b0, lat, busyc);
      chk("lat_stall2", lat, 7);
      chk("gt_1100_1011", int'({gt, lt, eq}), 4);

      abort_cmp(4'b1100, 4'b0011, 2);
      run_cmp(4'b0001, 4'b0000, 0, -1, 0, 1'b0, lat, busyc);
      chk("gt_after_rst", int'(gt), 1);

      run_cmp(4'b0101, 4'b0110, 0, -1, 0, 1'b1, lat, busyc);
      chk("lat_noise", lat, 5);
      chk("lt_noise", int'(lt), 1);
      idle(3, 4'b0101, 4'b0110, 1'b1);

      for (int n = 0; n < 80; n++) begin
         a = W'($urandom);
         case ($urandom_range(0, 2))
            0: b = a;
            1: b = a ^ (W'(1) << $urandom_range(0, W - 1));
            default: b = W'($urandom);
         endcase
         if ($urandom_range(0, 9) == 0) begin
            abort_cmp(a, b, $urandom_range(0, W - 1));
            idle(1, '0, '0, 1'b0);
         end
         run_cmp(a, b, 30, $urandom_range(0, W - 1), $urandom_range(0, 3), 1'b1, lat, busyc);
         idle($urandom_range(0, 3), a, b, 1'b1);
      end

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/serial_magnitude_comparator.md
# serial_magnitude_comparator

Bit-serial unsigned magnitude comparator built around the single-bit compare cell of the 5-week comparator lab. Two WIDTH-bit operands arrive MSB-first, one bit pair per accepted cycle. A small FSM accumulates the per-bit verdicts and reports a registered greater / less / equal result with a one-cycle done pulse. It sits directly downstream of the one-bit compare logic and extends it from a single bit to a multi-bit word.

## Interface
- WIDTH, 4, operand width in bits; legal range 2..16.
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous and active-high.
- start  input  1  begin a comparison; honoured only in IDLE.
- in_valid  input  1  a_bit/b_bit hold a valid bit pair this cycle.
- a_bit  input  1  current bit of operand A, MSB first.
- b_bit  input  1  current bit of operand B, MSB first.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse when the result becomes valid.
- gt  output  1  A > B.
- lt  output  1  A < B.
- eq  output  1  A == B.

## Operation
- States:
  - IDLE: waits for start.
  - SHIFT: consumes bit pairs.
  - DONE: asserts done for one cycle, then returns to IDLE.
- IDLE → SHIFT on start:
  - bit counter cnt cleared to 0.
  - decided flag cleared.
  - gt/lt/eq cleared to 0.
- In SHIFT, a bit pair is consumed on every edge where in_valid=1. With in_valid=0 the block stalls and all state holds.
- Per consumed pair, while decided=0:
  - a_bit=1, b_bit=0: set the A-greater verdict and set decided.
  - a_bit=0, b_bit=1: set the A-less verdict and set decided.
  - Equal bits: no change.
- Once decided=1, remaining bits are still consumed but ignored. The first differing bit from the MSB wins.
- cnt increments per consumed pair.
- SHIFT → DONE on the edge that consumes the pair with cnt=WIDTH-1. On that edge:
  - gt, lt and eq are loaded from the verdict; eq=1 iff decided=0.
  - done=1 during the DONE cycle.
- DONE → IDLE unconditionally. gt/lt/eq hold their values until the next accepted start or rst.
- Invariant: exactly one of gt/lt/eq is high after a completed comparison; all three are low before the first one.
- Ignored events:
  - start while in SHIFT or DONE.
  - in_valid while in IDLE or DONE.
- rst at any time, including mid-SHIFT:
  - next state IDLE.
  - busy=0, done=0, gt=0, lt=0, eq=0.
  - cnt=0, decided=0.
- start and rst in the same cycle: rst wins.

## Timing
- All outputs are registered. Reset value of every output is 0.
- start sampled at edge E0 → busy=1 from the cycle after E0.
- The first bit pair can be consumed at edge E0+1. There is no bit capture on the start edge itself.
- With in_valid held high: the last pair is consumed at E0+WIDTH. In the following cycle done=1, busy=0 and the result is valid. Start-to-done latency is WIDTH+1 cycles.
- Each in_valid=0 cycle during SHIFT adds exactly one cycle of latency.
- Earliest next accepted start is in the cycle after done, i.e. in IDLE.
- cnt is $clog2(WIDTH) bits wide and never wraps within a comparison.

## Structure
- Shared package or header holds:
  - state encoding constants: ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2.
  - verdict encoding constants: V_EQ, V_GT, V_LT.
- One sub-module: bit_compare_cell. It is purely combinational and maps (a_bit, b_bit) to (bit_gt, bit_lt, bit_eq). The FSM/datapath top instantiates it once.
- Top contains:
  - state register.
  - cnt.
  - decided/verdict registers.
  - output registers.

## Test plan
- WIDTH=4, A=1010, B=1001, in_valid held high → done exactly 5 cycles after start, with gt=1, lt=0, eq=0; busy high for 4 cycles.
- A=0110, B=0110 → eq=1 at done; gt=lt=0. Results hold for 10 idle cycles afterwards.
- A=0111, B=1000 → lt=1. The MSB decides; the later pairs (A bits 1, B bits 0) must not flip the verdict.
- A=1100, B=1011 with in_valid low for 2 cycles after bit 1 → done at start+7 cycles; gt=1.
- rst asserted after 2 bits consumed → all outputs 0 the next cycle. A new start with A=0001, B=0000 then completes normally with gt=1.
- start pulsed again mid-SHIFT, and in_valid pulsed while in IDLE → no restart, no extra bit consumed, and the result matches the original operands.
